// File: rtl/xor_slice_arbiter.sv
// Round-robin arbiter that time-shares one SLICE-wide XOR package among NREQ
// requesters, streaming each WIDTH-bit operand pair through it LSB slice first.
module xor_slice_arbiter #(
  parameter int NREQ  = 3,
  parameter int WIDTH = 12,
  parameter int SLICE = 4
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [NREQ-1:0]         REQ,
  input  logic [NREQ*WIDTH-1:0]   REQ_A,
  input  logic [NREQ*WIDTH-1:0]   REQ_B,
  output logic [NREQ-1:0]         GNT,
  output logic [NREQ-1:0]         DONE,
  output logic [WIDTH-1:0]        Y,
  output logic                    BUSY,
  output logic [SLICE-1:0]        GA,
  output logic [SLICE-1:0]        GB,
  input  logic [SLICE-1:0]        GY
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [WIDTH-1:0]  opa_q, opa_d;
  logic [WIDTH-1:0]  opb_q, opb_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [IDXW-1:0]   last_q, last_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [IDXW-1:0]   sel_s;
  logic              found_s;
  logic [SLICE-1:0]  ga_s, gb_s;

  // Round-robin pick: first requester above the last winner, wrapping.
  always_comb begin
    found_s = 1'b0;
    sel_s   = last_q;
    for (int off = 1; off <= NREQ; off++) begin
      int cand;
      cand = (int'(last_q) + off) % NREQ;
      if (!found_s && REQ[cand]) begin
        found_s = 1'b1;
        sel_s   = IDXW'(cand);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state and datapath decode; package pins are only driven during RUN.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    y_d     = y_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    last_d  = last_q;
    idx_d   = idx_q;
    ga_s    = '0;
    gb_s    = '0;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          state_d        = S_RUN;
          idx_d          = sel_s;
          opa_d          = REQ_A[sel_s*WIDTH +: WIDTH];
          opb_d          = REQ_B[sel_s*WIDTH +: WIDTH];
          gnt_d          = '0;
          gnt_d[sel_s]   = 1'b1;
          k_d            = '0;
          acc_d          = '0;
        end else begin
          gnt_d = '0;
        end
      end
      S_RUN: begin
        ga_s = opa_q[k_q*SLICE +: SLICE];
        gb_s = opb_q[k_q*SLICE +: SLICE];
        acc_d[k_q*SLICE +: SLICE] = GY;
        if (k_q == KW'(NSLICE - 1)) begin
          // Final slice is merged straight into Y so it does not wait a cycle.
          y_d     = acc_d;
          last_d  = idx_q;
          done_d  = gnt_q;
          state_d = S_FIN;
        end else begin
          k_d = k_q + {{(KW-1){1'b0}}, 1'b1};
        end
      end
      S_FIN: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      last_q  <= IDXW'(NREQ - 1);
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
    end
  end

  assign GNT  = gnt_q;
  assign DONE = done_q;
  assign Y    = y_q;
  assign BUSY = (state_q != S_IDLE);
  assign GA   = ga_s;
  assign GB   = gb_s;

endmodule

// File: tb/tb_xor_slice_arbiter.sv
// Directed bench for xor_slice_arbiter with a behavioural XOR package model.
module tb_xor_slice_arbiter;

  localparam int NREQ  = 3;
  localparam int WIDTH = 12;
  localparam int SLICE = 4;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      y;
  logic                  busy;
  logic [SLICE-1:0]      ga;
  logic [SLICE-1:0]      gb;
  logic [SLICE-1:0]      gy;

  int err_cnt = 0;
  int chk_cnt = 0;

  xor_slice_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .CLK(clk), .RST_N(rst_n), .REQ(req), .REQ_A(req_a), .REQ_B(req_b),
    .GNT(gnt), .DONE(done), .Y(y), .BUSY(busy), .GA(ga), .GB(gb), .GY(gy)
  );

  assign gy = ga ^ gb;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic check_idle_outs(input string tag);
    check_val({tag, "_gnt"},  32'(gnt),  32'h0);
    check_val({tag, "_done"}, 32'(done), 32'h0);
    check_val({tag, "_busy"}, 32'(busy), 32'h0);
    check_val({tag, "_ga"},   32'(ga),   32'h0);
    check_val({tag, "_gb"},   32'(gb),   32'h0);
  endtask

  logic [SLICE-1:0] exp_ga [3];
  logic [SLICE-1:0] exp_gb [3];
  int               rr_id  [4];
  logic [WIDTH-1:0] rr_y   [3];

  initial begin
    rst_n = 1'b0;
    req   = '0;
    req_a = '0;
    req_b = '0;
    exp_ga = '{4'hF, 4'h0, 4'hF};
    exp_gb = '{4'hF, 4'hF, 4'h0};
    rr_id  = '{0, 1, 2, 0};
    rr_y   = '{12'h575, 12'hA4C, 12'hA5A};

    // Reset state
    tick();
    tick();
    check_idle_outs("rst");
    check_val("rst_y", 32'(y), 32'h0);

    // 1. Single request
    rst_n = 1'b1;
    req   = 3'b001;
    set_ops(0, 12'hF0F, 12'h0FF);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_val($sformatf("t1_ga%0d", c + 1),  32'(ga),   32'(exp_ga[c]));
      check_val($sformatf("t1_gb%0d", c + 1),  32'(gb),   32'(exp_gb[c]));
      check_val($sformatf("t1_gnt%0d", c + 1), 32'(gnt),  32'h1);
      check_val($sformatf("t1_bsy%0d", c + 1), 32'(busy), 32'h1);
      check_val($sformatf("t1_dn%0d", c + 1),  32'(done), 32'h0);
    end
    tick();
    check_val("t1_done", 32'(done), 32'h1);
    check_val("t1_y",    32'(y),    32'hFF0);
    check_val("t1_gnt4", 32'(gnt),  32'h1);
    check_val("t1_bsy4", 32'(busy), 32'h1);
    check_val("t1_ga4",  32'(ga),   32'h0);
    req = 3'b000;

    // 6. Y hold with no requests
    for (int c = 0; c < 10; c++) begin
      tick();
      check_val("t6_y", 32'(y), 32'hFF0);
      check_idle_outs("t6");
    end

    // 2. Round-robin fairness from a fresh pointer
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_ops(0, 12'h123, 12'h456);
    set_ops(1, 12'hABC, 12'h0F0);
    set_ops(2, 12'h5A5, 12'hFFF);
    req = 3'b111;
    for (int n = 0; n < 4; n++) begin
      tick();
      check_val($sformatf("t2_gnt%0d", n), 32'(gnt), 32'(1 << rr_id[n]));
      tick();
      tick();
      tick();
      check_val($sformatf("t2_done%0d", n), 32'(done), 32'(1 << rr_id[n]));
      check_val($sformatf("t2_y%0d", n),    32'(y),    32'(rr_y[rr_id[n]]));
      tick();
      check_val($sformatf("t2_idle%0d", n), 32'(busy), 32'h0);
      if (n == 3) req = 3'b000;
    end

    // 3. Operand stability and late request
    req = 3'b001;
    set_ops(0, 12'h123, 12'h321);
    tick();
    check_val("t3_gnt0", 32'(gnt), 32'h1);
    set_ops(0, 12'hFFF, 12'h321);
    req = 3'b011;
    tick();
    tick();
    tick();
    check_val("t3_done", 32'(done), 32'h1);
    check_val("t3_y",    32'(y),    32'h202);
    req = 3'b010;
    tick();
    check_val("t3_idle", 32'(gnt), 32'h0);
    tick();
    check_val("t3_gnt1", 32'(gnt), 32'h2);
    tick();
    tick();
    tick();
    check_val("t3_done1", 32'(done), 32'h2);
    check_val("t3_y1",    32'(y),    32'hA4C);
    req = 3'b000;
    tick();

    // 4. Dropped request mid-run
    req = 3'b001;
    set_ops(0, 12'h0F0, 12'h00F);
    tick();
    check_val("t4_gnt", 32'(gnt), 32'h1);
    tick();
    req = 3'b000;
    tick();
    tick();
    check_val("t4_done", 32'(done), 32'h1);
    check_val("t4_y",    32'(y),    32'h0FF);
    tick();
    check_idle_outs("t4_a");
    tick();
    check_idle_outs("t4_b");

    // 5. Reset mid-operation
    req = 3'b001;
    set_ops(0, 12'h111, 12'h222);
    tick();
    tick();
    rst_n = 1'b0;
    req   = 3'b100;
    tick();
    check_idle_outs("t5_rst");
    check_val("t5_y0", 32'(y), 32'h0);
    rst_n = 1'b1;
    tick();
    check_val("t5_gnt",   32'(gnt),  32'h4);
    check_val("t5_nodn",  32'(done), 32'h0);
    req = 3'b100;
    tick();
    tick();
    tick();
    check_val("t5_done", 32'(done), 32'h4);
    check_val("t5_y",    32'(y),    32'hA5A);
    req = 3'b000;
    tick();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
